des_session_ctrl: RTL and testbench

//  Sequences one DES operation: collects a 64-bit key, then a 64-bit data block, from the
//  hex entry front end, launches the DES core, and holds the result for display.

---
 rtl/des_session_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_des_session_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_session_ctrl.sv
// des_session_ctrl: collects key and data from the hex entry block, runs the DES core once, holds the result.
// Optional core watchdog is enabled by defining WATCHDOG_EN.
module des_session_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_entry_full,
    input  logic [63:0] i_entry_val,
    input  logic        i_go_n,
    input  logic        i_abort_n,
    input  logic        i_mode,
    output logic        o_entry_rst_n,
    output logic        o_des_start,
    output logic [63:0] o_des_key,
    output logic [63:0] o_des_data,
    output logic        o_des_dec,
    input  logic        i_des_done,
    input  logic [63:0] i_des_result,
    output logic [63:0] o_result,
    output logic        o_result_vld,
    output logic [2:0]  o_phase,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_GET_KEY    = 3'd0,
        S_LATCH_KEY  = 3'd1,
        S_GET_DATA   = 3'd2,
        S_LATCH_DATA = 3'd3,
        S_RUN        = 3'd4,
        S_WAIT       = 3'd5,
        S_SHOW       = 3'd6,
        S_ERROR      = 3'd7
    } state_t;

    if (2**TW <= TIMEOUT) begin : g_cfg_check
        $error("des_session_ctrl: TW too narrow for TIMEOUT");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic        r_go_n;
    logic        r_go_n_prev;
    logic        r_vld;
    logic        r_err;
    logic        r_dec;
    logic [63:0] r_key;
    logic [63:0] r_data;
    logic [63:0] r_result;
    logic        w_go;
    logic        w_abort;
    logic        w_latch_key;
    logic        w_latch_data;
    logic        w_capture;
    logic        w_vld_clr;
    logic        w_wd_hit;

    assign w_go    = r_go_n_prev & ~r_go_n;
    assign w_abort = ~i_abort_n;

`ifdef WATCHDOG_EN
    logic [TW-1:0] r_wd;

    assign w_wd_hit = (r_wd == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_wd <= '0;
        else if (r_state == S_RUN) r_wd <= '0;
        else if (r_state == S_WAIT) r_wd <= r_wd + TW'(1);
    end
`else
    assign w_wd_hit = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        o_entry_rst_n = 1'b1;
        o_des_start   = 1'b0;
        w_latch_key   = 1'b0;
        w_latch_data  = 1'b0;
        w_capture     = 1'b0;
        w_vld_clr     = 1'b0;
        case (r_state)
            S_GET_KEY: begin
                if (w_abort) begin
                    o_entry_rst_n = 1'b0;
                    w_vld_clr     = 1'b1;
                end else if (w_go && i_entry_full) begin
                    w_state_next = S_LATCH_KEY;
                end
            end
            S_LATCH_KEY: begin
                o_entry_rst_n = 1'b0;
                if (w_abort) begin
                    w_vld_clr    = 1'b1;
                    w_state_next = S_GET_KEY;
                end else begin
                    w_latch_key  = 1'b1;
                    w_state_next = S_GET_DATA;
                end
            end
            S_GET_DATA: begin
                if (w_abort) begin
                    o_entry_rst_n = 1'b0;
                    w_vld_clr     = 1'b1;
                    w_state_next  = S_GET_KEY;
                end else if (w_go && i_entry_full) begin
                    w_state_next = S_LATCH_DATA;
                end
            end
            S_LATCH_DATA: begin
                o_entry_rst_n = 1'b0;
                w_vld_clr     = 1'b1;
                if (w_abort) begin
                    w_state_next = S_GET_KEY;
                end else begin
                    w_latch_data = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    o_entry_rst_n = 1'b0;
                    w_vld_clr     = 1'b1;
                    w_state_next  = S_GET_KEY;
                end else begin
                    o_des_start  = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            // abort is deliberately ignored here: the core run in flight must complete
            S_WAIT: begin
                if (i_des_done) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SHOW;
                end else if (w_wd_hit) begin
                    w_vld_clr    = 1'b1;
                    w_state_next = S_ERROR;
                end
            end
            S_SHOW: begin
                if (w_abort)   w_state_next = S_GET_KEY;
                else if (w_go) w_state_next = S_GET_DATA;
            end
            S_ERROR: begin
                if (w_abort) w_state_next = S_GET_KEY;
            end
            default: w_state_next = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_GET_KEY;
            r_go_n      <= 1'b1;
            r_go_n_prev <= 1'b1;
            r_vld       <= 1'b0;
            r_err       <= 1'b0;
            r_dec       <= 1'b0;
            r_key       <= '0;
            r_data      <= '0;
            r_result    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_go_n      <= i_go_n;
            r_go_n_prev <= r_go_n;
            r_err       <= (w_state_next == S_ERROR);
            if (w_latch_key) r_key <= i_entry_val;
            if (w_latch_data) begin
                r_data <= i_entry_val;
                r_dec  <= i_mode;
            end
            if (w_capture) begin
                r_result <= i_des_result;
                r_vld    <= 1'b1;
            end else if (w_vld_clr) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign o_des_key    = r_key;
    assign o_des_data   = r_data;
    assign o_des_dec    = r_dec;
    assign o_result     = r_result;
    assign o_result_vld = r_vld;
    assign o_phase      = r_state;
    assign o_err        = r_err;

endmodule

// File: tb/tb_des_session_ctrl.sv
// Self-checking bench for des_session_ctrl; expected core operations are queued and checked at des_start/result.
// Define WATCHDOG_EN for both files to also exercise the watchdog path (TIMEOUT=16 here).
module tb_des_session_ctrl;
    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] DAT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] RES1 = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY3 = 64'hA5A5_0F0F_3C3C_9696;
    localparam logic [63:0] DAT2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] RES2 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] DAT3 = 64'h0BAD_F00D_DEAD_BEEF;
    localparam logic [63:0] RES3 = 64'h9999_AAAA_BBBB_CCCC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_entry_full = 1'b0;
    logic [63:0] i_entry_val = '0;
    logic        i_go_n = 1'b1;
    logic        i_abort_n = 1'b1;
    logic        i_mode = 1'b0;
    logic        i_des_done = 1'b0;
    logic [63:0] i_des_result = '0;
    logic        o_entry_rst_n, o_des_start, o_des_dec, o_result_vld, o_err;
    logic [63:0] o_des_key, o_des_data, o_result;
    logic [2:0]  o_phase;

    typedef struct {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] res;
    } exp_t;
    exp_t sb_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int rst_cnt = 0;
    int start_cnt = 0;
    int lk_cnt = 0;
    int ld_cnt = 0;

    des_session_ctrl #(.TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst(rst),
        .i_entry_full(i_entry_full), .i_entry_val(i_entry_val),
        .i_go_n(i_go_n), .i_abort_n(i_abort_n), .i_mode(i_mode),
        .o_entry_rst_n(o_entry_rst_n), .o_des_start(o_des_start),
        .o_des_key(o_des_key), .o_des_data(o_des_data), .o_des_dec(o_des_dec),
        .i_des_done(i_des_done), .i_des_result(i_des_result),
        .o_result(o_result), .o_result_vld(o_result_vld),
        .o_phase(o_phase), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (!o_entry_rst_n) rst_cnt++;
            if (o_des_start) start_cnt++;
            if (o_phase == 3'd1) lk_cnt++;
            if (o_phase == 3'd3) ld_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        i_go_n = 1'b0;
        repeat (hold) cyc();
        i_go_n = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic go_and_start(output bit found, output int lat);
        found = 1'b0;
        lat = 0;
        i_go_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            lat++;
            if (lat == 1) i_go_n = 1'b1;
            if (o_des_start) begin
                found = 1'b1;
                break;
            end
        end
        i_go_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        n_total++; if (o_phase !== 3'd0) $display("FAIL reset_phase got %0d exp 0", o_phase); else n_pass++;
        n_total++; if (o_entry_rst_n !== 1'b1 || o_des_start !== 1'b0) $display("FAIL reset_ctrl got rst_n=%b start=%b exp 1/0", o_entry_rst_n, o_des_start); else n_pass++;
        n_total++; if (o_des_key !== 64'd0 || o_result !== 64'd0 || o_result_vld !== 1'b0 || o_err !== 1'b0)
            $display("FAIL reset_regs got key=%h res=%h vld=%b err=%b exp zeros", o_des_key, o_result, o_result_vld, o_err); else n_pass++;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_full_op();
        bit found; int lat; int r0; exp_t e;
        i_entry_full = 1'b1;
        i_entry_val = KEY1;
        r0 = rst_cnt;
        press(1);
        n_total++; if (o_phase !== 3'd2 || o_des_key !== KEY1) $display("FAIL key_latch got phase=%0d key=%h exp 2/%h", o_phase, o_des_key, KEY1); else n_pass++;
        n_total++; if (rst_cnt - r0 !== 1) $display("FAIL key_clear_pulse got %0d exp 1", rst_cnt - r0); else n_pass++;
        i_entry_val = DAT1;
        i_mode = 1'b0;
        sb_q.push_back('{key: KEY1, data: DAT1, dec: 1'b0, res: RES1});
        go_and_start(found, lat);
        n_total++; if (!found || lat != 3) $display("FAIL start_latency got found=%b lat=%0d exp 1/3", found, lat); else n_pass++;
        e = sb_q.pop_front();
        n_total++; if (o_des_key !== e.key || o_des_data !== e.data || o_des_dec !== e.dec)
            $display("FAIL op1_operands got %h %h %b exp %h %h %b", o_des_key, o_des_data, o_des_dec, e.key, e.data, e.dec); else n_pass++;
        cyc();
        i_des_done = 1'b1;
        i_des_result = e.res;
        cyc();
        i_des_done = 1'b0;
        i_des_result = '0;
        n_total++; if (o_phase !== 3'd6 || o_result !== e.res || o_result_vld !== 1'b1)
            $display("FAIL op1_result got phase=%0d res=%h vld=%b exp 6/%h/1", o_phase, o_result, o_result_vld, e.res); else n_pass++;
        n_total++; if (start_cnt !== 1) $display("FAIL op1_start_count got %0d exp 1", start_cnt); else n_pass++;
    endtask

    task automatic test_go_held();
        int r0; int k0;
        i_abort_n = 1'b0;
        cyc();
        i_abort_n = 1'b1;
        cyc();
        n_total++; if (o_phase !== 3'd0) $display("FAIL show_abort got phase=%0d exp 0", o_phase); else n_pass++;
        i_entry_full = 1'b1;
        i_entry_val = KEY3;
        r0 = rst_cnt;
        k0 = lk_cnt;
        i_go_n = 1'b0;
        repeat (50) cyc();
        i_go_n = 1'b1;
        repeat (3) cyc();
        n_total++; if (lk_cnt - k0 !== 1 || rst_cnt - r0 !== 1)
            $display("FAIL go_held got latch=%0d clear=%0d exp 1/1", lk_cnt - k0, rst_cnt - r0); else n_pass++;
        n_total++; if (o_phase !== 3'd2 || o_des_key !== KEY3) $display("FAIL go_held_key got phase=%0d key=%h exp 2/%h", o_phase, o_des_key, KEY3); else n_pass++;
    endtask

    task automatic test_not_full();
        int r0;
        i_entry_full = 1'b0;
        r0 = rst_cnt;
        press(1);
        repeat (2) cyc();
        n_total++; if (o_phase !== 3'd2 || rst_cnt - r0 !== 0) $display("FAIL not_full got phase=%0d clear=%0d exp 2/0", o_phase, rst_cnt - r0); else n_pass++;
        i_des_done = 1'b1;
        i_des_result = 64'hDEAD_DEAD_DEAD_DEAD;
        cyc();
        i_des_done = 1'b0;
        cyc();
        n_total++; if (o_phase !== 3'd2 || o_result !== RES1) $display("FAIL done_outside_wait got phase=%0d res=%h exp 2/%h", o_phase, o_result, RES1); else n_pass++;
    endtask

    task automatic test_second_op();
        bit found; int lat; int s0; exp_t e;
        i_entry_full = 1'b1;
        i_entry_val = DAT2;
        i_mode = 1'b1;
        s0 = start_cnt;
        sb_q.push_back('{key: KEY3, data: DAT2, dec: 1'b1, res: RES2});
        go_and_start(found, lat);
        n_total++; if (!found) $display("FAIL op2_start got none exp pulse"); else n_pass++;
        e = sb_q.pop_front();
        n_total++; if (o_des_key !== e.key || o_des_data !== e.data || o_des_dec !== e.dec)
            $display("FAIL op2_operands got %h %h %b exp %h %h %b", o_des_key, o_des_data, o_des_dec, e.key, e.data, e.dec); else n_pass++;
        i_des_done = 1'b1;
        i_des_result = 64'hBAD0_BAD0_BAD0_BAD0;
        cyc();
        i_des_done = 1'b0;
        n_total++; if (o_phase !== 3'd5 || o_result_vld !== 1'b0) $display("FAIL done_in_run got phase=%0d vld=%b exp 5/0", o_phase, o_result_vld); else n_pass++;
        i_des_done = 1'b1;
        i_des_result = e.res;
        cyc();
        i_des_done = 1'b0;
        n_total++; if (o_phase !== 3'd6 || o_result !== e.res || o_result_vld !== 1'b1)
            $display("FAIL op2_result got phase=%0d res=%h vld=%b exp 6/%h/1", o_phase, o_result, o_result_vld, e.res); else n_pass++;
        n_total++; if (start_cnt - s0 !== 1) $display("FAIL op2_start_count got %0d exp 1", start_cnt - s0); else n_pass++;
    endtask

    task automatic test_abort();
        int d0;
        press(1);
        n_total++; if (o_phase !== 3'd2 || o_result_vld !== 1'b1) $display("FAIL show_go got phase=%0d vld=%b exp 2/1", o_phase, o_result_vld); else n_pass++;
        i_abort_n = 1'b0;
        #1;
        n_total++; if (o_entry_rst_n !== 1'b0) $display("FAIL abort_pulse got %b exp 0", o_entry_rst_n); else n_pass++;
        cyc();
        i_abort_n = 1'b1;
        cyc();
        n_total++; if (o_phase !== 3'd0 || o_result_vld !== 1'b0 || o_des_key !== KEY3 || o_des_data !== DAT2)
            $display("FAIL abort_state got phase=%0d vld=%b key=%h data=%h", o_phase, o_result_vld, o_des_key, o_des_data); else n_pass++;
        press(1);
        d0 = ld_cnt;
        i_go_n = 1'b0;
        i_abort_n = 1'b0;
        repeat (3) cyc();
        i_go_n = 1'b1;
        i_abort_n = 1'b1;
        repeat (2) cyc();
        n_total++; if (o_phase !== 3'd0 || ld_cnt - d0 !== 0) $display("FAIL abort_wins got phase=%0d latches=%0d exp 0/0", o_phase, ld_cnt - d0); else n_pass++;
    endtask

    task automatic test_abort_in_wait();
        bit found; int lat; exp_t e;
        i_entry_val = KEY1;
        press(1);
        i_entry_val = DAT3;
        i_mode = 1'b0;
        sb_q.push_back('{key: KEY1, data: DAT3, dec: 1'b0, res: RES3});
        go_and_start(found, lat);
        e = sb_q.pop_front();
        n_total++; if (!found || o_des_key !== e.key || o_des_data !== e.data || o_des_dec !== e.dec)
            $display("FAIL op3_operands got found=%b %h %h %b exp %h %h %b", found, o_des_key, o_des_data, o_des_dec, e.key, e.data, e.dec); else n_pass++;
        cyc();
        i_abort_n = 1'b0;
        repeat (3) cyc();
        n_total++; if (o_phase !== 3'd5) $display("FAIL abort_in_wait got phase=%0d exp 5", o_phase); else n_pass++;
        i_abort_n = 1'b1;
        i_des_done = 1'b1;
        i_des_result = e.res;
        cyc();
        i_des_done = 1'b0;
        n_total++; if (o_phase !== 3'd6 || o_result !== e.res) $display("FAIL op3_result got phase=%0d res=%h exp 6/%h", o_phase, o_result, e.res); else n_pass++;
    endtask

`ifdef WATCHDOG_EN
    task automatic test_watchdog();
        bit found; int lat; int n;
        press(1);
        go_and_start(found, lat);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (o_phase != 3'd5) break;
            n++;
        end
        n_total++; if (!found || n != 16 || o_phase !== 3'd7) $display("FAIL wd_timeout got found=%b waits=%0d phase=%0d exp 1/16/7", found, n, o_phase); else n_pass++;
        n_total++; if (o_err !== 1'b1 || o_result_vld !== 1'b0) $display("FAIL wd_err got err=%b vld=%b exp 1/0", o_err, o_result_vld); else n_pass++;
        i_abort_n = 1'b0;
        cyc();
        i_abort_n = 1'b1;
        cyc();
        n_total++; if (o_phase !== 3'd0 || o_err !== 1'b0) $display("FAIL wd_abort got phase=%0d err=%b exp 0/0", o_phase, o_err); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_wait();
        bit found; int lat; exp_t e;
        if (o_phase == 3'd0) press(1);
        else press(1);
        i_entry_val = DAT1;
        sb_q.push_back('{key: o_des_key, data: DAT1, dec: i_mode, res: RES1});
        go_and_start(found, lat);
        e = sb_q.pop_front();
        n_total++; if (!found || o_des_data !== e.data) $display("FAIL op4_start got found=%b data=%h exp 1/%h", found, o_des_data, e.data); else n_pass++;
        cyc();
        n_total++; if (o_phase !== 3'd5) $display("FAIL op4_wait got phase=%0d exp 5", o_phase); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (o_phase !== 3'd0 || o_des_key !== 64'd0 || o_des_data !== 64'd0 || o_result !== 64'd0 || o_result_vld !== 1'b0
                       || o_des_start !== 1'b0 || o_entry_rst_n !== 1'b1 || o_err !== 1'b0 || o_des_dec !== 1'b0)
            $display("FAIL reset_mid_wait got phase=%0d key=%h data=%h res=%h vld=%b", o_phase, o_des_key, o_des_data, o_result, o_result_vld); else n_pass++;
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_full_op();
        test_go_held();
        test_not_full();
        test_second_op();
        test_abort();
        test_abort_in_wait();
`ifdef WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid_wait();
        n_total++; if (sb_q.size() != 0) $display("FAIL scoreboard_left got %0d exp 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "bench timeout");
    end
endmodule
